// File: rtl/marv32_alu_issue.sv
// marv32_alu_issue
//   ALU issue stage: decodes RV32 OP / OP-IMM instructions into ALU operands
//   and an ALU opcode, and buffers decoded items in a 2-entry skid buffer so
//   that in_ready_out is a pure register with no path from out_ready_in.
//
// Ports
//   clk_in, reset_in              clock, synchronous active-high reset
//   instr_in, in_valid_in         instruction word and upstream valid
//   in_ready_out                  stage can accept (low only when both entries full)
//   rs1_data_in, rs2_data_in      register-file data for instr[19:15] / instr[24:20]
//   wb_en_in, wb_rd_in,
//   wb_data_in                    writeback bus, used for operand forwarding
//   out_valid_out, out_ready_in   downstream handshake
//   op_1_out, op_2_out            ALU operands
//   opcode_out                    {sub/sra flag, funct3}
//   rd_out                        destination register
//   illegal_out                   item was not an OP / OP-IMM instruction
//
// Configuration
//   MARV32_ISSUE_FWD_EN           when defined, the writeback bus is forwarded into
//                                 rs1/rs2 at acceptance; otherwise wb_* is ignored.

module marv32_alu_issue (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] instr_in,
    input  logic        in_valid_in,
    output logic        in_ready_out,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_data_in,
    output logic        out_valid_out,
    input  logic        out_ready_in,
    output logic [31:0] op_1_out,
    output logic [31:0] op_2_out,
    output logic [3:0]  opcode_out,
    output logic [4:0]  rd_out,
    output logic        illegal_out
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic        illegal;
        logic [3:0]  opcode;
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [4:0]  rd;
    } item_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    state_t state;
    item_t  head;   // item currently presented
    item_t  skid;   // item caught while head was stalled
    item_t  dec;

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        accept;
    logic        drain;

    assign opc     = instr_in[6:0];
    assign funct3  = instr_in[14:12];
    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];

    // Source operand selection; x0 always reads as zero, even over forwarding.
`ifdef MARV32_ISSUE_FWD_EN
    always_comb begin
        rs1_val = rs1_data_in;
        rs2_val = rs2_data_in;
        if (wb_en_in && (wb_rd_in != 5'd0) && (wb_rd_in == rs1_idx)) rs1_val = wb_data_in;
        if (wb_en_in && (wb_rd_in != 5'd0) && (wb_rd_in == rs2_idx)) rs2_val = wb_data_in;
        if (rs1_idx == 5'd0) rs1_val = '0;
        if (rs2_idx == 5'd0) rs2_val = '0;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en_in, wb_rd_in, wb_data_in};

    always_comb begin
        rs1_val = (rs1_idx == 5'd0) ? '0 : rs1_data_in;
        rs2_val = (rs2_idx == 5'd0) ? '0 : rs2_data_in;
    end
`endif

    always_comb begin
        dec = '0;
        case (opc)
            OPC_OP: begin
                dec.op_1      = rs1_val;
                dec.op_2      = rs2_val;
                dec.opcode    = {((funct3 == 3'b000) || (funct3 == 3'b101)) ? instr_in[30] : 1'b0,
                                 funct3};
                dec.rd        = instr_in[11:7];
            end
            OPC_OP_IMM: begin
                dec.op_1      = rs1_val;
                // Shift-immediates carry only the 5-bit shamt; funct7 bits are not data.
                if ((funct3 == 3'b001) || (funct3 == 3'b101))
                    dec.op_2  = {27'b0, instr_in[24:20]};
                else
                    dec.op_2  = {{20{instr_in[31]}}, instr_in[31:20]};
                dec.opcode    = {(funct3 == 3'b101) ? instr_in[30] : 1'b0, funct3};
                dec.rd        = instr_in[11:7];
            end
            default: begin
                dec.illegal   = 1'b1;
            end
        endcase
    end

    assign accept = in_valid_in && in_ready_out;
    assign drain  = out_valid_out && out_ready_in;

    // Skid FSM. in_ready_out and out_valid_out are registered alongside the state
    // so neither handshake output has a combinational path from the other side.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= EMPTY;
            head          <= '0;
            skid          <= '0;
            out_valid_out <= 1'b0;
            in_ready_out  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head          <= dec;
                        state         <= ONE;
                        out_valid_out <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head <= dec;
                    end else if (accept) begin
                        skid         <= dec;
                        state        <= TWO;
                        in_ready_out <= 1'b0;
                    end else if (drain) begin
                        state         <= EMPTY;
                        out_valid_out <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        head         <= skid;
                        state        <= ONE;
                        in_ready_out <= 1'b1;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    out_valid_out <= 1'b0;
                    in_ready_out  <= 1'b1;
                end
            endcase
        end
    end

    assign op_1_out    = head.op_1;
    assign op_2_out    = head.op_2;
    assign opcode_out  = head.opcode;
    assign rd_out      = head.rd;
    assign illegal_out = head.illegal;

endmodule

// File: tb/tb_marv32_alu_issue.sv
// tb_marv32_alu_issue
//   Directed bench for marv32_alu_issue: decode of OP / OP-IMM, x0 handling,
//   illegal items, skid-buffer ordering under backpressure, reset while full,
//   and writeback forwarding (expectations follow MARV32_ISSUE_FWD_EN).

module tb_marv32_alu_issue;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] instr_in;
    logic        in_valid_in;
    logic        in_ready_out;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;
    logic        wb_en_in;
    logic [4:0]  wb_rd_in;
    logic [31:0] wb_data_in;
    logic        out_valid_out;
    logic        out_ready_in;
    logic [31:0] op_1_out;
    logic [31:0] op_2_out;
    logic [3:0]  opcode_out;
    logic [4:0]  rd_out;
    logic        illegal_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD    = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADD_X0 = 32'h002001B3; // add  x3,x0,x2
    localparam logic [31:0] I_SRAI   = 32'h40435293; // srai x5,x6,4
    localparam logic [31:0] I_ADDI   = 32'hFFF10093; // addi x1,x2,-1
    localparam logic [31:0] I_SUB    = 32'h40108233; // sub  x4,x1,x1
    localparam logic [31:0] I_LW     = 32'h0000A283; // lw   x5,0(x1)

    marv32_alu_issue dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .instr_in      (instr_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .rs1_data_in   (rs1_data_in),
        .rs2_data_in   (rs2_data_in),
        .wb_en_in      (wb_en_in),
        .wb_rd_in      (wb_rd_in),
        .wb_data_in    (wb_data_in),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .op_1_out      (op_1_out),
        .op_2_out      (op_2_out),
        .opcode_out    (opcode_out),
        .rd_out        (rd_out),
        .illegal_out   (illegal_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_item(input string tag, input logic ill, input logic [3:0] opc,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        chk({tag, ".valid"},   {31'b0, out_valid_out}, 32'd1);
        chk({tag, ".illegal"}, {31'b0, illegal_out},   {31'b0, ill});
        chk({tag, ".opcode"},  {28'b0, opcode_out},    {28'b0, opc});
        chk({tag, ".op1"},     op_1_out,               a);
        chk({tag, ".op2"},     op_2_out,               b);
        chk({tag, ".rd"},      {27'b0, rd_out},        {27'b0, rd});
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        instr_in    = ins;
        rs1_data_in = r1;
        rs2_data_in = r2;
        in_valid_in = 1'b1;
    endtask

    initial begin
        reset_in     = 1'b1;
        instr_in     = '0;
        in_valid_in  = 1'b0;
        rs1_data_in  = '0;
        rs2_data_in  = '0;
        wb_en_in     = 1'b0;
        wb_rd_in     = '0;
        wb_data_in   = '0;
        out_ready_in = 1'b1;

        // Reset state, with a valid item offered that must be ignored.
        step();
        drive(I_ADD, 32'd5, 32'd7);
        step();
        chk("rst.valid",   {31'b0, out_valid_out}, 32'd0);
        chk("rst.ready",   {31'b0, in_ready_out},  32'd1);
        chk("rst.illegal", {31'b0, illegal_out},   32'd0);
        chk("rst.op1",     op_1_out,               32'd0);
        chk("rst.op2",     op_2_out,               32'd0);
        chk("rst.opcode",  {28'b0, opcode_out},    32'd0);
        chk("rst.rd",      {27'b0, rd_out},        32'd0);
        reset_in    = 1'b0;
        in_valid_in = 1'b0;
        step();
        chk("idle.valid", {31'b0, out_valid_out}, 32'd0);

        // ADD x3,x1,x2: one-cycle latency.
        drive(I_ADD, 32'd5, 32'd7);
        step();
        in_valid_in = 1'b0;
        chk_item("add", 1'b0, 4'b0000, 32'd5, 32'd7, 5'd3);
        step();
        chk("add.drained", {31'b0, out_valid_out}, 32'd0);

        // SRAI x5,x6,4 with negative rs1.
        drive(I_SRAI, 32'h80000000, 32'h0);
        step();
        in_valid_in = 1'b0;
        chk_item("srai", 1'b0, 4'b1101, 32'h80000000, 32'd4, 5'd5);
        step();

        // ADDI with imm 0xFFF sign-extends to -1.
        drive(I_ADDI, 32'h100, 32'h0);
        step();
        in_valid_in = 1'b0;
        chk_item("addi", 1'b0, 4'b0000, 32'h100, 32'hFFFFFFFF, 5'd1);
        step();

        // LW is not an ALU op: flagged illegal with all fields zeroed.
        drive(I_LW, 32'h55, 32'h66);
        step();
        in_valid_in = 1'b0;
        chk_item("lw", 1'b1, 4'b0000, 32'd0, 32'd0, 5'd0);
        step();

        // rs1 = x0 reads as zero regardless of register-file data.
        drive(I_ADD_X0, 32'h1234, 32'd9);
        step();
        in_valid_in = 1'b0;
        chk_item("x0", 1'b0, 4'b0000, 32'd0, 32'd9, 5'd3);
        step();

        // Backpressure: A, B accepted, C refused, then drained in order.
        out_ready_in = 1'b0;
        drive(I_ADD, 32'hA1, 32'hA2);
        step();
        chk("skid.a.ready", {31'b0, in_ready_out}, 32'd1);
        chk_item("skid.a", 1'b0, 4'b0000, 32'hA1, 32'hA2, 5'd3);
        drive(I_ADDI, 32'hB1, 32'hB2);
        step();
        chk("skid.b.ready", {31'b0, in_ready_out}, 32'd0);
        chk_item("skid.hold1", 1'b0, 4'b0000, 32'hA1, 32'hA2, 5'd3);
        drive(I_SUB, 32'hC1, 32'hC2);
        step();
        chk("skid.c.ready", {31'b0, in_ready_out}, 32'd0);
        chk_item("skid.hold2", 1'b0, 4'b0000, 32'hA1, 32'hA2, 5'd3);
        out_ready_in = 1'b1;
        step();
        chk_item("skid.out_b", 1'b0, 4'b0000, 32'hB1, 32'hFFFFFFFF, 5'd1);
        chk("skid.ready_back", {31'b0, in_ready_out}, 32'd1);
        step();
        in_valid_in = 1'b0;
        chk_item("skid.out_c", 1'b0, 4'b1000, 32'hC1, 32'hC2, 5'd4);
        step();
        chk("skid.empty", {31'b0, out_valid_out}, 32'd0);
        step();
        chk("skid.nodup", {31'b0, out_valid_out}, 32'd0);

        // Reset while both entries are full discards them.
        out_ready_in = 1'b0;
        drive(I_ADD, 32'hD1, 32'hD2);
        step();
        drive(I_SRAI, 32'hE1, 32'hE2);
        step();
        chk("rst2.full", {31'b0, in_ready_out}, 32'd0);
        reset_in = 1'b1;
        drive(I_SUB, 32'hF1, 32'hF2);
        step();
        chk("rst2.valid", {31'b0, out_valid_out}, 32'd0);
        chk("rst2.ready", {31'b0, in_ready_out},  32'd1);
        chk("rst2.op1",   op_1_out,               32'd0);
        chk("rst2.rd",    {27'b0, rd_out},        32'd0);
        reset_in     = 1'b0;
        in_valid_in  = 1'b0;
        out_ready_in = 1'b1;
        step();
        chk("rst2.after1", {31'b0, out_valid_out}, 32'd0);
        step();
        chk("rst2.after2", {31'b0, out_valid_out}, 32'd0);

        // Writeback forwarding.
        wb_en_in   = 1'b1;
        wb_rd_in   = 5'd1;
        wb_data_in = 32'hAA;
        drive(I_SUB, 32'h11, 32'h11);
        step();
        in_valid_in = 1'b0;
`ifdef MARV32_ISSUE_FWD_EN
        chk_item("fwd.sub", 1'b0, 4'b1000, 32'hAA, 32'hAA, 5'd4);
`else
        chk_item("fwd.sub", 1'b0, 4'b1000, 32'h11, 32'h11, 5'd4);
`endif
        step();

        wb_rd_in = 5'd0;
        drive(I_SUB, 32'h11, 32'h11);
        step();
        in_valid_in = 1'b0;
        chk_item("fwd.rd0", 1'b0, 4'b1000, 32'h11, 32'h11, 5'd4);
        step();

        // Only rs2 (x2) matches: sources are forwarded independently.
        wb_rd_in = 5'd2;
        drive(I_ADD, 32'h11, 32'h22);
        step();
        in_valid_in = 1'b0;
`ifdef MARV32_ISSUE_FWD_EN
        chk_item("fwd.rs2", 1'b0, 4'b0000, 32'h11, 32'hAA, 5'd3);
`else
        chk_item("fwd.rs2", 1'b0, 4'b0000, 32'h11, 32'h22, 5'd3);
`endif
        step();
        wb_en_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/marv32_alu_issue.md
MARV32_ALU_ISSUE -- requirements
Module: marv32_alu_issue

Interface
REQ-001 SHALL have ports: clk_in  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset_in  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: instr_in  input  32  RV32 instruction word; in_valid_in  input  1  instr/operands valid; in_ready_out  output  1  stage can accept.
REQ-004 SHALL have ports: rs1_data_in, rs2_data_in  input  32 each  register-file read data for instr_in[19:15] and [24:20].
REQ-005 SHALL have ports: wb_en_in  input  1, wb_rd_in  input  5, wb_data_in  input  32  writeback bus used for forwarding.
REQ-006 SHALL have ports: out_valid_out  output  1; out_ready_in  input  1  ALU-side consumer ready.
REQ-007 SHALL have ports: op_1_out, op_2_out  output  32  ALU operands; opcode_out  output  4  ALU opcode {sub/sra flag, funct3}; rd_out  output  5  destination; illegal_out  output  1  non-ALU instruction flag.

Function
REQ-008 SHALL accept an item when in_valid_in && in_ready_out on a rising edge; SHALL present it when out_valid_out && out_ready_in.
REQ-009 SHALL have latency exactly 1 cycle from acceptance to out_valid_out with an empty buffer.
REQ-010 SHALL implement a 2-entry skid buffer with states EMPTY, ONE, TWO; EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE->ONE on simultaneous accept and drain; ONE->TWO on accept without drain; TWO->ONE on drain.
REQ-011 SHALL drive in_ready_out = 0 only in state TWO, from a register (no combinational path from out_ready_in).
REQ-012 SHALL keep all output fields stable while out_valid_out && !out_ready_in; presented order SHALL equal accepted order.
REQ-013 SHALL decode OP (opcode 0110011): op_2 = rs2 data; opcode_out[2:0] = funct3; opcode_out[3] = instr[30] when funct3 is 000 or 101, else 0.
REQ-014 SHALL decode OP-IMM (0010011): op_2 = sign-extended instr[31:20]; for funct3 001/101 op_2 = {27'b0, instr[24:20]}; opcode_out[3] = instr[30] only for funct3 101, else 0.
REQ-015 SHALL set op_1 = rs1 data for OP and OP-IMM.
REQ-016 SHALL treat register index 0 as value 0 regardless of rs1_data_in/rs2_data_in or writeback.
REQ-017 SHALL, for any other opcode, accept and present the item with illegal_out = 1, opcode_out = 0, op_1_out = 0, op_2_out = 0, rd_out = 0.
REQ-018 SHALL set rd_out = instr[11:7] for legal items.

Reset
REQ-019 SHALL, when reset_in is high at a rising edge, enter EMPTY, drop any buffered items, and drive out_valid_out = 0, in_ready_out = 1, illegal_out = 0, and op_1_out, op_2_out, opcode_out, rd_out = 0.
REQ-020 SHALL ignore in_valid_in while reset_in is high; reset asserted mid-stall SHALL discard held items with no output handshake.

Configuration
REQ-021 SHALL gate writeback forwarding with macro MARV32_ISSUE_FWD_EN.
REQ-022 SHALL, with MARV32_ISSUE_FWD_EN defined, substitute wb_data_in for rs1/rs2 data at acceptance when wb_en_in = 1, wb_rd_in != 0 and wb_rd_in equals the source index; rs1 and rs2 SHALL be checked independently.
REQ-023 SHALL, without MARV32_ISSUE_FWD_EN, use rs1_data_in/rs2_data_in unchanged and ignore the wb_* inputs.

Verification
REQ-024 Bench SHALL check: ADD x3,x1,x2 (instr 0x002081B3), rs1 = 5, rs2 = 7, out_ready_in = 1 -> next cycle out_valid_out = 1, op_1 = 5, op_2 = 7, opcode = 0000, rd = 3.
REQ-025 Bench SHALL check: SRAI x5,x6,4 (0x40435293), rs1 = 0x80000000 -> op_2 = 4, opcode = 1101; ADDI imm 0xFFF -> op_2 = 0xFFFFFFFF, opcode = 0000.
REQ-026 Bench SHALL check: out_ready_in = 0, three back-to-back valid items -> first two accepted, in_ready_out = 0 on the third; after release, items A, B, C are presented in order with no loss or duplication.
REQ-027 Bench SHALL check: with MARV32_ISSUE_FWD_EN, wb_en_in = 1, wb_rd_in = 1, wb_data_in = 0xAA, SUB x4,x1,x1 -> op_1 = op_2 = 0xAA; with wb_rd_in = 0 -> raw data used; without the macro -> raw data used.
REQ-028 Bench SHALL check: LW instruction (opcode 0000011) -> illegal_out = 1, all operands 0; instruction reading x0 with rs1_data_in = 0x1234 -> op_1 = 0.
REQ-029 Bench SHALL check: reset_in asserted in state TWO -> next cycle out_valid_out = 0, in_ready_out = 1, and no held item appears after release.
